vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
Shares the single-port video RAM between the video controller's pixel fetch and a host read/write port. The block sits between vidcon and the VRAM BRAM and runs in the 65 MHz dot-clock domain. Video fetches have absolute priority and fixed latency. Host accesses use free cycles, with a req/ack handshake and a starvation monitor.

Parameters:
ADDR_W, 16, VRAM address width
DATA_W, 8, VRAM data width
STARVE_MAX, 1024, host wait cycles before host_starved sets
STARVE_W, 11, width of starvation counter (must hold STARVE_MAX)

Ports:
sys_clk  in  1  dot clock (65 MHz); the only clock
sys_reset  in  1  reset, asynchronous, active-low
vid_req  in  1  video fetch strobe, one read per high cycle
vid_addr  in  ADDR_W  video fetch address
vid_data  out  DATA_W  video read data
vid_valid  out  1  vid_data valid
host_req  in  1  host request, held until host_ack
host_we  in  1  1 = write, 0 = read
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_ack  out  1  one-cycle completion pulse
host_rdata  out  DATA_W  host read data, valid with host_ack on reads
host_starved  out  1  sticky starvation flag
starve_clr  in  1  clears host_starved and the counter
mem_en  out  1  BRAM enable
mem_we  out  1  BRAM write enable
mem_addr  out  ADDR_W  BRAM address
mem_wdata  out  DATA_W  BRAM write data
mem_rdata  in  DATA_W  BRAM read data, 1-cycle registered read

Behaviour:
- One clock only. Reset is asynchronous and active-low on sys_reset.
- All outputs are registered. Reset value of every output is 0.
- Reset also clears the tag pipeline, host_busy, and the starvation counter.
- Grant at each edge:
  - vid_req=1: issue a video read.
  - else host_req=1 and host_busy=0: issue the host access and set host_busy.
  - else: mem_en=0.
- Issue means the mem_* outputs are driven from the sampled inputs in the following cycle. mem_we=1 only for host writes.
- Tag pipeline has 2 stages; each stage holds {valid, owner(video/host), is_read}.
- Fixed latency of 2 edges from the sampling edge:
  - Video: vid_valid=1 and vid_data=mem_rdata, registered.
  - Host: host_ack=1 for both reads and writes. host_rdata=mem_rdata on reads; unchanged on writes.
- Video accepts back-to-back every cycle, i.e. a fully pipelined throughput of 1/cycle.
- One outstanding host access at a time. host_busy clears on the edge that raises host_ack.
- host_addr, host_we and host_wdata are sampled only at the grant edge; later changes are ignored.
- If host_req is still high in the cycle after host_ack, it is a new request. Earliest regrant is the edge after ack, which gives the host one access per 3 cycles.
- Host cannot preempt video. A host request waits indefinitely while vid_req=1.
- Starvation counter:
  - Increments each edge where host_req=1, host_busy=0 and the host is not granted.
  - Resets to 0 on a host grant.
  - Saturates at STARVE_MAX; reaching STARVE_MAX sets host_starved.
- starve_clr=1 clears host_starved and the counter. On the same edge as a set condition, clear wins; the counter restarts from 0.
- Reset asserted mid-operation:
  - In-flight accesses are dropped; no vid_valid or host_ack is produced for them.
  - mem_en and mem_we go to 0 immediately (async). The host must re-issue.
- Address wrap: none needed. Addresses pass through unmodified over the full 2^ADDR_W range.

Test Plan:
- Video stream: vid_req=1 for 8 cycles, addrs 0x0000..0x0007, BRAM preloaded with data=addr[7:0] -> vid_valid high for 8 cycles starting 2 edges after the first request; vid_data 0x00..0x07 in order; host_ack stays 0.
- Host write then read, video idle: write 0x1234<-0xA5 -> host_ack 2 edges after grant; mem_we high for exactly 1 cycle. Then read 0x1234 -> host_ack with host_rdata=0xA5.
- Contention: host_req held while vid_req=1 for 5 cycles then 0 -> host granted on the first edge with vid_req=0; ack 2 edges later; video data unaffected.
- Starvation: STARVE_MAX=16, vid_req=1 continuously with host_req held -> host_starved rises after 16 waiting edges and stays high after vid_req drops. starve_clr pulse -> host_starved=0.
- Reset mid-read: assert sys_reset low 1 cycle after host read grant -> all outputs 0 at once, no host_ack after release. A re-issued read completes normally.
- Interleave: vid_req alternating 1/0 with host_req held -> host is granted only in vid_req=0 cycles, at most one access per 3 cycles. Video results return every requested cycle at latency 2.

Source files
------------

// File: rtl/vram_arbiter_if.sv
// Bus bundle between the VRAM arbiter, its two requesters (video fetch, host port)
// and the single-port VRAM BRAM. The arbiter takes the slave view.
interface vram_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_data;
  logic              vid_valid;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;
  logic              host_starved;
  logic              starve_clr;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  vid_req, vid_addr, host_req, host_we, host_addr, host_wdata, starve_clr, mem_rdata,
    output vid_data, vid_valid, host_ack, host_rdata, host_starved,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output vid_req, vid_addr, host_req, host_we, host_addr, host_wdata, starve_clr, mem_rdata,
    input  vid_data, vid_valid, host_ack, host_rdata, host_starved,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetch has absolute priority at fixed 2-edge latency,
// the host port uses idle cycles with one access outstanding and a starvation monitor.
module vram_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned STARVE_MAX = 1024,
  parameter int unsigned STARVE_W   = 11
) (
  input logic            sys_clk,
  input logic            sys_reset,
  vram_arbiter_if.slave  io_bus
);

  localparam logic [STARVE_W-1:0] StarveMax = STARVE_W'(STARVE_MAX);

  typedef struct packed {
    logic valid;
    logic host;   // 0 = video owner, 1 = host owner
    logic rd;
  } tag_t;

  logic              w_vid_grant;
  logic              w_host_grant;
  logic              w_host_wait;
  logic              w_host_done;
  logic              w_vid_done;

  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  tag_t              r_tag1;
  tag_t              r_tag2;
  logic              r_vid_valid;
  logic [DATA_W-1:0] r_vid_data;
  logic              r_host_ack;
  logic [DATA_W-1:0] r_host_rdata;
  logic              r_host_busy;
  logic [STARVE_W-1:0] r_starve_cnt;
  logic              r_host_starved;

  assign w_vid_grant  = io_bus.vid_req;
  assign w_host_grant = ~io_bus.vid_req & io_bus.host_req & ~r_host_busy;
  assign w_host_wait  = io_bus.host_req & ~r_host_busy & ~w_host_grant;
  assign w_vid_done   = r_tag2.valid & ~r_tag2.host;
  assign w_host_done  = r_tag2.valid & r_tag2.host;

  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      r_mem_en       <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_tag1         <= '0;
      r_tag2         <= '0;
      r_vid_valid    <= 1'b0;
      r_vid_data     <= '0;
      r_host_ack     <= 1'b0;
      r_host_rdata   <= '0;
      r_host_busy    <= 1'b0;
      r_starve_cnt   <= '0;
      r_host_starved <= 1'b0;
    end else begin
      r_mem_en <= w_vid_grant | w_host_grant;
      r_mem_we <= w_host_grant & io_bus.host_we;
      if (w_vid_grant) begin
        r_mem_addr <= io_bus.vid_addr;
      end else if (w_host_grant) begin
        r_mem_addr  <= io_bus.host_addr;
        r_mem_wdata <= io_bus.host_wdata;
      end

      // Tag travels alongside the BRAM's one-cycle read so results land 2 edges after grant.
      r_tag1 <= '{valid: w_vid_grant | w_host_grant,
                  host:  w_host_grant,
                  rd:    w_vid_grant | ~io_bus.host_we};
      r_tag2 <= r_tag1;

      r_vid_valid <= w_vid_done;
      if (w_vid_done) r_vid_data <= io_bus.mem_rdata;

      r_host_ack <= w_host_done;
      if (w_host_done && r_tag2.rd) r_host_rdata <= io_bus.mem_rdata;

      if (w_host_grant) begin
        r_host_busy <= 1'b1;
      end else if (w_host_done) begin
        r_host_busy <= 1'b0;
      end

      // Clear beats a simultaneous set; the flag is sticky otherwise.
      if (io_bus.starve_clr) begin
        r_starve_cnt   <= '0;
        r_host_starved <= 1'b0;
      end else if (w_host_grant) begin
        r_starve_cnt <= '0;
      end else if (w_host_wait && (r_starve_cnt != StarveMax)) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
        if ((r_starve_cnt + 1'b1) == StarveMax) r_host_starved <= 1'b1;
      end
    end
  end

  assign io_bus.mem_en       = r_mem_en;
  assign io_bus.mem_we       = r_mem_we;
  assign io_bus.mem_addr     = r_mem_addr;
  assign io_bus.mem_wdata    = r_mem_wdata;
  assign io_bus.vid_valid    = r_vid_valid;
  assign io_bus.vid_data     = r_vid_data;
  assign io_bus.host_ack     = r_host_ack;
  assign io_bus.host_rdata   = r_host_rdata;
  assign io_bus.host_starved = r_host_starved;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: expected responses are queued at issue time and a
// negedge monitor pops and compares data and arrival cycle whenever the DUT responds.
module tb_vram_arbiter;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;

  typedef struct {
    int         due;
    logic [7:0] data;
  } exp_t;

  logic sys_clk = 1'b0;
  logic sys_reset = 1'b0;
  always #5 sys_clk = ~sys_clk;

  vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

  vram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(16), .STARVE_W(5)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_reset(sys_reset),
    .io_bus   (bif)
  );

  // BRAM model: unwritten locations read back as addr[7:0].
  logic [7:0] ram     [0:65535];
  logic       written [0:65535];
  always @(posedge sys_clk) begin
    if (bif.mem_en) begin
      if (bif.mem_we) begin
        ram[bif.mem_addr]     <= bif.mem_wdata;
        written[bif.mem_addr] <= 1'b1;
      end
      bif.mem_rdata <= (written[bif.mem_addr] === 1'b1) ? ram[bif.mem_addr] : bif.mem_addr[7:0];
    end
  end

  int cyc = 0;
  int we_cnt = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;
  always @(negedge sys_clk) if (bif.mem_we) we_cnt <= we_cnt + 1;

  int   checks = 0;
  int   errors = 0;
  exp_t vid_q[$];
  exp_t host_q[$];
  int   we_base;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic exp_vid(input logic [7:0] d);
    exp_t e;
    e.due  = cyc + 3;
    e.data = d;
    vid_q.push_back(e);
  endtask

  task automatic exp_host(input int lat, input logic [7:0] d);
    exp_t e;
    e.due  = cyc + lat;
    e.data = d;
    host_q.push_back(e);
  endtask

  task automatic wait_ack();
    int n = 0;
    while (!bif.host_ack && n < 40) begin
      step();
      n++;
    end
    if (!bif.host_ack) begin
      checks++;
      errors++;
      $display("FAIL host_ack_timeout: got no ack expected ack within 40 cycles");
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (bif.vid_valid) begin
        check("vid_pending", 32'(vid_q.size() != 0), 1);
        if (vid_q.size() != 0) begin
          e = vid_q.pop_front();
          check("vid_data", bif.vid_data, e.data);
          check("vid_latency", cyc, e.due);
        end
      end
      if (bif.host_ack) begin
        check("host_pending", 32'(host_q.size() != 0), 1);
        if (host_q.size() != 0) begin
          e = host_q.pop_front();
          check("host_rdata", bif.host_rdata, e.data);
          check("host_latency", cyc, e.due);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    bif.vid_req = 0; bif.vid_addr = '0; bif.host_req = 0; bif.host_we = 0;
    bif.host_addr = '0; bif.host_wdata = '0; bif.starve_clr = 0;
    fork
      monitor();
    join_none

    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_vid_valid", bif.vid_valid, 0);
    check("rst_vid_data", bif.vid_data, 0);
    check("rst_host_ack", bif.host_ack, 0);
    check("rst_host_rdata", bif.host_rdata, 0);
    check("rst_starved", bif.host_starved, 0);
    check("rst_mem_en", bif.mem_en, 0);
    check("rst_mem_we", bif.mem_we, 0);
    check("rst_mem_addr", bif.mem_addr, 0);
    check("rst_mem_wdata", bif.mem_wdata, 0);
    sys_reset = 1;
    step();

    // Video stream 0x0000..0x0007
    for (int i = 0; i < 8; i++) begin
      bif.vid_req = 1; bif.vid_addr = 16'(i);
      exp_vid(8'(i));
      step();
    end
    bif.vid_req = 0;
    repeat (4) step();
    check("stream_drained", vid_q.size(), 0);

    // Host write 0x1234 <- 0xA5; address/data changes after grant must be ignored
    we_base = we_cnt;
    bif.host_req = 1; bif.host_we = 1; bif.host_addr = 16'h1234; bif.host_wdata = 8'hA5;
    exp_host(3, 8'h00);
    step();
    bif.host_we = 0; bif.host_addr = 16'hFFFF; bif.host_wdata = 8'h00;
    wait_ack();
    bif.host_req = 0;
    step();
    check("write_we_pulses", we_cnt - we_base, 1);

    // Host read back
    bif.host_req = 1; bif.host_we = 0; bif.host_addr = 16'h1234;
    exp_host(3, 8'hA5);
    step();
    wait_ack();
    bif.host_req = 0;
    step();

    // Contention: host waits through 5 video cycles
    bif.host_req = 1; bif.host_we = 0; bif.host_addr = 16'h1234;
    exp_host(8, 8'hA5);
    for (int i = 0; i < 5; i++) begin
      bif.vid_req = 1; bif.vid_addr = 16'h0010 + 16'(i);
      exp_vid(8'h10 + 8'(i));
      step();
    end
    bif.vid_req = 0;
    wait_ack();
    bif.host_req = 0;
    step();
    check("contention_no_starve", bif.host_starved, 0);

    // Starvation with STARVE_MAX=16
    bif.host_req = 1; bif.host_we = 0; bif.host_addr = 16'h0042;
    for (int i = 0; i < 20; i++) begin
      bif.vid_req = 1; bif.vid_addr = 16'h0100 + 16'(i);
      exp_vid(8'(i));
      step();
      if (i == 14) check("starve_at_15", bif.host_starved, 0);
      if (i == 15) check("starve_at_16", bif.host_starved, 1);
    end
    bif.vid_req = 0;
    exp_host(3, 8'h42);
    wait_ack();
    bif.host_req = 0;
    step();
    check("starve_sticky", bif.host_starved, 1);
    bif.starve_clr = 1;
    step();
    bif.starve_clr = 0;
    check("starve_cleared", bif.host_starved, 0);
    step();

    // Reset right after a host read grant: in-flight read is dropped
    bif.host_req = 1; bif.host_we = 0; bif.host_addr = 16'h0055;
    step();
    check("mid_mem_en_issued", bif.mem_en, 1);
    sys_reset = 0; bif.host_req = 0;
    #1;
    check("mid_rst_mem_en", bif.mem_en, 0);
    check("mid_rst_mem_we", bif.mem_we, 0);
    check("mid_rst_mem_addr", bif.mem_addr, 0);
    check("mid_rst_host_ack", bif.host_ack, 0);
    step();
    sys_reset = 1;
    repeat (5) step();
    bif.host_req = 1;
    exp_host(3, 8'h55);
    step();
    wait_ack();
    bif.host_req = 0;
    step();

    // Interleave: vid_req toggles, host held; host grants at E2, E6, E10
    bif.host_req = 1; bif.host_we = 0; bif.host_addr = 16'h0077;
    exp_host(4, 8'h77);
    exp_host(8, 8'h77);
    exp_host(12, 8'h77);
    for (int k = 0; k < 12; k++) begin
      bif.vid_req = (k % 2 == 0);
      if (k % 2 == 0) begin
        bif.vid_addr = 16'h0200 + 16'(k);
        exp_vid(8'(k));
      end
      step();
    end
    bif.host_req = 0; bif.vid_req = 0;
    repeat (6) step();
    check("final_vid_q_empty", vid_q.size(), 0);
    check("final_host_q_empty", host_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
